// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring subtract-shift step per clock; signs are fixed up in a final cycle.
module mult_div_unit (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] Operand_A,
  input  logic [31:0] Operand_B,
  input  logic        Write_Hi,
  input  logic        Write_Lo,
  input  logic [31:0] Write_Data,
  output logic        Busy,
  output logic        Done,
  output logic        Div_By_Zero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  // state | meaning
  // IDLE  | waiting for Start; MTHI/MTLO strobes accepted here
  // RUN   | 32 iteration steps, one per edge
  // FIX   | sign correction, HI/LO update, Done raised
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic        r_is_div, r_neg_q, r_neg_r, r_b_zero;
  logic [31:0] r_acc_hi, r_acc_lo, r_b, r_raw_a;
  logic [31:0] r_hi, r_lo;
  logic        r_done, r_dbz;

  logic        w_accept, w_signed;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_mul_sum, w_trial;
  logic [31:0] w_step_hi, w_step_lo;
  logic [63:0] w_prod, w_prod_fix;
  logic [31:0] w_quo_fix, w_rem_fix;

  assign w_accept = (r_state == S_IDLE) && Start;
  assign w_signed = ~Op[0];
  assign w_mag_a  = (w_signed && Operand_A[31]) ? -Operand_A : Operand_A;
  assign w_mag_b  = (w_signed && Operand_B[31]) ? -Operand_B : Operand_B;

  // r_acc_hi holds partial product / partial remainder, r_acc_lo the multiplier / quotient bits
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_trial   = {r_acc_hi, r_acc_lo[31]} - {1'b0, r_b};

  always_comb begin
    w_step_hi = 32'd0;
    w_step_lo = 32'd0;
    if (!r_is_div) begin
      w_step_hi = w_mul_sum[32:1];
      w_step_lo = {w_mul_sum[0], r_acc_lo[31:1]};
    end else if (!w_trial[32]) begin
      w_step_hi = w_trial[31:0];
      w_step_lo = {r_acc_lo[30:0], 1'b1};
    end else begin
      w_step_hi = {r_acc_hi[30:0], r_acc_lo[31]};
      w_step_lo = {r_acc_lo[30:0], 1'b0};
    end
  end

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_b      <= 32'd0;
      r_raw_a  <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      if (w_accept) begin
        r_cnt    <= 5'd0;
        r_is_div <= Op[1];
        r_neg_q  <= w_signed & (Operand_A[31] ^ Operand_B[31]);
        r_neg_r  <= w_signed & Operand_A[31];
        r_b_zero <= (Operand_B == 32'd0);
        r_acc_hi <= 32'd0;
        r_acc_lo <= w_mag_a;
        r_b      <= w_mag_b;
        r_raw_a  <= Operand_A;
        r_dbz    <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (Write_Hi) r_hi <= Write_Data;
        if (Write_Lo) r_lo <= Write_Data;
      end else if (r_state == S_RUN) begin
        r_cnt    <= r_cnt + 5'd1;
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
      end else if (r_state == S_FIX) begin
        if (!r_is_div) begin
          r_hi <= w_prod_fix[63:32];
          r_lo <= w_prod_fix[31:0];
        end else if (r_b_zero) begin
          r_hi  <= r_raw_a;
          r_lo  <= 32'hFFFF_FFFF;
          r_dbz <= 1'b1;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end
      end
    end
  end

  assign Busy        = (r_state != S_IDLE);
  assign Done        = r_done;
  assign Div_By_Zero = r_dbz;
  assign Hi          = r_hi;
  assign Lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model of HI/LO and the divide-by-zero flag.
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Operand_A, Operand_B;
  logic        Write_Hi, Write_Lo;
  logic [31:0] Write_Data;
  logic        Busy, Done, Div_By_Zero;
  logic [31:0] Hi, Lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_dbz = 1'b0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mult_div_unit dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Op(Op),
    .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Write_Hi(Write_Hi), .Write_Lo(Write_Lo), .Write_Data(Write_Data),
    .Busy(Busy), .Done(Done), .Div_By_Zero(Div_By_Zero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definition of each operation.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edbz);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    edbz = 1'b0;
    if (op == MULT) begin
      sa = $signed(a); sb = $signed(b);
      p  = 64'(sa * sb);
      ehi = p[63:32]; elo = p[31:0];
    end else if (op == MULTU) begin
      p  = {32'd0, a} * {32'd0, b};
      ehi = p[63:32]; elo = p[31:0];
    end else if (b == 32'd0) begin
      ehi = a; elo = 32'hFFFF_FFFF; edbz = 1'b1;
    end else if (op == DIV) begin
      sa = $signed(a); sb = $signed(b);
      sq = sa / sb; sr = sa % sb;
      ehi = sr[31:0]; elo = sq[31:0];
    end else begin
      ehi = a % b; elo = a / b;
    end
  endtask

  // Drives Start immediately (so a call right after Done exercises back-to-back issue),
  // then follows the operation to its Done pulse.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit wr_start);
    logic [31:0] ehi, elo;
    logic        edbz;
    int          got, busy_n;
    model(op, a, b, ehi, elo, edbz);
    Op = op; Operand_A = a; Operand_B = b; Start = 1'b1;
    if (wr_start) begin
      Write_Hi = 1'b1; Write_Lo = 1'b1; Write_Data = $urandom;
    end
    got = 0; busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clock); #1;
      if (i == 1) begin
        Start = 1'b0; Write_Hi = 1'b0; Write_Lo = 1'b0;
        Operand_A = $urandom; Operand_B = $urandom; Op = 2'($urandom);
        check_eq("dbz_cleared_on_start", {63'd0, Div_By_Zero}, 64'd0);
      end
      if (disturb && i == 5) begin
        Start = 1'b1; Write_Hi = 1'b1; Write_Lo = 1'b1; Write_Data = $urandom;
      end
      if (disturb && i == 6) begin
        Start = 1'b0; Write_Hi = 1'b0; Write_Lo = 1'b0;
      end
      if (Busy) busy_n++;
      if (Done) begin
        got = i;
        break;
      end
      if (i == 20) check_eq("hilo_hold_busy", {Hi, Lo}, {m_hi, m_lo});
    end
    check_eq("latency", 64'(got), 64'd34);
    check_eq("busy_cycles", 64'(busy_n), 64'd33);
    m_hi = ehi; m_lo = elo; m_dbz = edbz;
    check_eq("hi", {32'd0, Hi}, {32'd0, m_hi});
    check_eq("lo", {32'd0, Lo}, {32'd0, m_lo});
    check_eq("dbz", {63'd0, Div_By_Zero}, {63'd0, m_dbz});
  endtask

  task automatic idle_cycle();
    @(posedge Clock); #1;
    check_eq("done_one_cycle", {63'd0, Done}, 64'd0);
    check_eq("idle_busy", {63'd0, Busy}, 64'd0);
  endtask

  task automatic mt(input logic whi, input logic wlo, input logic [31:0] data);
    Write_Hi = whi; Write_Lo = wlo; Write_Data = data;
    @(posedge Clock); #1;
    Write_Hi = 1'b0; Write_Lo = 1'b0;
    if (whi) m_hi = data;
    if (wlo) m_lo = data;
    check_eq("mt_hi", {32'd0, Hi}, {32'd0, m_hi});
    check_eq("mt_lo", {32'd0, Lo}, {32'd0, m_lo});
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; Operand_A = 32'd0; Operand_B = 32'd0;
    Write_Hi = 1'b0; Write_Lo = 1'b0; Write_Data = 32'd0;
    #12;
    check_eq("rst_busy", {63'd0, Busy}, 64'd0);
    check_eq("rst_done", {63'd0, Done}, 64'd0);
    check_eq("rst_dbz", {63'd0, Div_By_Zero}, 64'd0);
    check_eq("rst_hilo", {Hi, Lo}, 64'd0);
    #11 Reset_n = 1'b1;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0);
    check_eq("mult_neg3x7", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    check_eq("div_neg7_2", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    check_eq("divu_100_7", {Hi, Lo}, {32'd2, 32'd14});
    run_op(DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
    check_eq("divu_by0", {Hi, Lo}, {32'd5, 32'hFFFF_FFFF});
    idle_cycle();
    check_eq("dbz_held", {63'd0, Div_By_Zero}, 64'd1);
    run_op(MULTU, 32'd12345, 32'd678, 1'b0, 1'b0);
    idle_cycle();

    mt(1'b0, 1'b1, 32'h1234_5678);
    run_op(MULTU, 32'd6, 32'd7, 1'b1, 1'b0);
    idle_cycle();
    mt(1'b1, 1'b1, 32'hCAFE_F00D);
    mt(1'b1, 1'b0, 32'h0BAD_BEEF);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check_eq("div_min_neg1", {Hi, Lo}, {32'h0, 32'h8000_0000});
    run_op(DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(2'($urandom), ra, rb, bit'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Abort mid-operation with an asynchronous reset.
    idle_cycle();
    Op = MULTU; Operand_A = 32'd2; Operand_B = 32'd3; Start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clock); #1;
      Start = 1'b0;
    end
    #1 Reset_n = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    check_eq("async_rst_busy", {63'd0, Busy}, 64'd0);
    check_eq("async_rst_hilo", {Hi, Lo}, 64'd0);
    check_eq("async_rst_dbz", {63'd0, Div_By_Zero}, 64'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock); #1;
      if (Done || Busy) seen++;
    end
    check_eq("no_done_after_abort", 64'(seen), 64'd0);
    check_eq("hilo_after_abort", {Hi, Lo}, 64'd0);
    run_op(MULTU, 32'd2, 32'd3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; all widths SHALL be fixed at 32-bit operands and 32-bit HI/LO.
REQ-002 Clock  input  1  single clock; all state SHALL change on posedge Clock.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Operand_A  input  32  rs value from register-file Read_Data1 (multiplicand / dividend).
REQ-007 Operand_B  input  32  rt value from register-file Read_Data2 (multiplier / divisor).
REQ-008 Write_Hi, Write_Lo  input  1 each  MTHI / MTLO strobes.
REQ-009 Write_Data  input  32  data for MTHI / MTLO.
REQ-010 Busy  output  1  high while an operation is in progress.
REQ-011 Done  output  1  one-cycle pulse when Hi/Lo receive a result.
REQ-012 Div_By_Zero  output  1  flag for the last completed division.
REQ-013 Hi, Lo  output  32 each  architectural HI/LO registers, for MFHI / MFLO.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FIX; Busy=1 exactly in RUN and FIX.
REQ-015 IDLE with Start=1 at edge E0: latch Op, operand magnitudes (signed ops) or raw values (unsigned ops), and result-sign bits; clear counter; go to RUN.
REQ-016 RUN SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per edge for 32 edges (E1..E32), then go to FIX.
REQ-017 FIX at E33 SHALL apply sign correction, write Hi/Lo, set Done=1 for the following cycle only, and return to IDLE; total latency is Start edge to Done visible = 34 cycles.
REQ-018 Multiply: {Hi,Lo} = full 64-bit product, two's complement for MULT, unsigned for MULTU.
REQ-019 Divide: Lo = quotient, Hi = remainder; DIV quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0x00000000 with no flag.
REQ-021 Divisor=0 (DIV or DIVU): same 34-cycle latency; Lo=0xFFFFFFFF, Hi=Operand_A as latched (raw); Div_By_Zero=1 with Done.
REQ-022 Div_By_Zero SHALL hold until the next accepted Start, which clears it; multiplies SHALL leave it 0.
REQ-023 Start while Busy=1 SHALL be ignored with no queuing.
REQ-024 Start in the Done cycle SHALL be accepted, because the state is IDLE; back-to-back operations are legal.
REQ-025 Write_Hi / Write_Lo in IDLE with Start=0 SHALL load Write_Data into Hi / Lo at the edge; both strobes together SHALL load both registers.
REQ-026 Write strobes while Busy=1, or coincident with an accepted Start, SHALL be ignored.
REQ-027 Hi/Lo SHALL change only under REQ-017 or REQ-025 and hold otherwise.
REQ-028 Operand_A / Operand_B changes after E0 SHALL NOT affect the result.

Reset
REQ-029 Reset_n=0 SHALL immediately, independent of Clock, force: state IDLE, Busy=0, Done=0, Div_By_Zero=0, Hi=0, Lo=0, counter=0.
REQ-030 Reset mid-operation SHALL abort the operation; no Done SHALL follow and no partial result SHALL reach Hi/Lo.
REQ-031 First Start SHALL be accepted on the first posedge after Reset_n rises.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Done 34 cycles after Start; Hi=0xFFFFFFFE, Lo=0x00000001; Busy high for 33 cycles.
REQ-033 MULT 0xFFFFFFFD (-3) x 0x00000007 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; then DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-034 DIVU 100 / 7 -> Lo=14, Hi=2, Div_By_Zero=0; then DIVU 5 / 0 -> Lo=0xFFFFFFFF, Hi=5, Div_By_Zero=1; next MULTU Start clears the flag.
REQ-035 MTLO 0x12345678 in IDLE -> Lo=0x12345678 next cycle; MTHI and a second Start issued while Busy -> both ignored and Hi/Lo unchanged until Done.
REQ-036 Start issued in the Done cycle -> accepted, second Done exactly 34 cycles later.
REQ-037 Start MULTU 2 x 3, Reset_n low at cycle 10 -> Busy=0, Hi=Lo=0 without waiting for a clock edge, and no Done within 40 cycles after release.
